// File: rtl/datapath_pkg.sv
// datapath_pkg: opcodes, flag bit positions and default sizes
// shared by the datapath_pn execute core and its ALU.
package datapath_pkg;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_NOT = 4'd5;
    localparam logic [3:0] OP_SHL = 4'd6;
    localparam logic [3:0] OP_SHR = 4'd7;
    localparam logic [3:0] OP_ADC = 4'd8;
    localparam logic [3:0] OP_SBC = 4'd9;
    localparam logic [3:0] OP_MOV = 4'd10;
    localparam logic [3:0] OP_CMP = 4'd11;

    localparam int FLAG_Z = 0;
    localparam int FLAG_C = 1;
    localparam int FLAG_N = 2;
    localparam int FLAG_V = 3;

    // want_regs=0 -> default DATA_W, want_regs=1 -> default REG_COUNT
    function automatic int default_size(input bit want_regs);
        return want_regs ? 16 : 8;
    endfunction

endpackage

// File: rtl/datapath_alu.sv
// datapath_alu: combinational ALU for datapath_pn.
// in: a, b, cin, op; out: result, carry, ovf, wr_valid (op writes a reg).
module datapath_alu
    import datapath_pkg::*;
#(
    parameter int DATA_W = default_size(1'b0)
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              cin,
    input  logic [3:0]        op,
    output logic [DATA_W-1:0] result,
    output logic              carry,
    output logic              ovf,
    output logic              wr_valid
);

    localparam int MSB = DATA_W - 1;

    logic          add_c;
    logic          sub_c;
    logic [DATA_W:0] sum;
    logic [DATA_W:0] dif;

    always_comb begin
        add_c    = (op == OP_ADC) && cin;
        sub_c    = (op == OP_SBC) && cin;
        sum      = {1'b0, a} + {1'b0, b} + {{DATA_W{1'b0}}, add_c};
        // top bit of the widened difference is the borrow
        dif      = {1'b0, a} - {1'b0, b} - {{DATA_W{1'b0}}, sub_c};
        result   = '0;
        carry    = 1'b0;
        ovf      = 1'b0;
        wr_valid = 1'b1;
        case (op)
            OP_ADD, OP_ADC: begin
                result = sum[MSB:0];
                carry  = sum[DATA_W];
                ovf    = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
            end
            OP_SUB, OP_SBC, OP_CMP: begin
                result   = dif[MSB:0];
                carry    = dif[DATA_W];
                ovf      = (a[MSB] != b[MSB]) && (dif[MSB] != a[MSB]);
                wr_valid = (op != OP_CMP);
            end
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_XOR: result = a ^ b;
            OP_NOT: result = ~a;
            OP_SHL: begin
                result = {a[MSB-1:0], 1'b0};
                carry  = a[MSB];
            end
            OP_SHR: begin
                result = {1'b0, a[MSB:1]};
                carry  = a[0];
            end
            OP_MOV: result = b;
            default: wr_valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/datapath_pn.sv
// datapath_pn: register file + ALU execute core with registered flags.
// Ports: clk, rst_n (sync, low), user write, two read ports, alu_en/opcode, Z/C/N/V.
module datapath_pn
    import datapath_pkg::*;
#(
    parameter int DATA_W    = default_size(1'b0),
    parameter int REG_COUNT = default_size(1'b1),
    parameter int ADDR_W    = $clog2(REG_COUNT)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              write_en,
    input  logic [ADDR_W-1:0] write_addr,
    input  logic [DATA_W-1:0] user_write_data,
    input  logic [ADDR_W-1:0] ra_addr,
    input  logic [ADDR_W-1:0] rb_addr,
    input  logic              alu_en,
    input  logic [3:0]        alu_opcode,
    output logic [DATA_W-1:0] read_a,
    output logic [DATA_W-1:0] read_b,
    output logic              alu_zero,
    output logic              alu_carry,
    output logic              alu_neg,
    output logic              alu_ovf
);

    logic [DATA_W-1:0] regs [REG_COUNT];
    logic [3:0]        flags;

    logic [DATA_W-1:0] res;
    logic              res_c;
    logic              res_v;
    logic              res_wr;
    logic              flag_en;
    logic [3:0]        flag_nxt;

    assign read_a = regs[ra_addr];
    assign read_b = regs[rb_addr];

    datapath_alu #(.DATA_W(DATA_W)) u_alu (
        .a        (read_a),
        .b        (read_b),
        .cin      (flags[FLAG_C]),
        .op       (alu_opcode),
        .result   (res),
        .carry    (res_c),
        .ovf      (res_v),
        .wr_valid (res_wr)
    );

    // every defined opcode, CMP included, updates the flags
    assign flag_en = (alu_opcode <= OP_CMP);

    always_comb begin
        flag_nxt         = '0;
        flag_nxt[FLAG_Z] = (res == '0);
        flag_nxt[FLAG_C] = res_c;
        flag_nxt[FLAG_N] = res[DATA_W-1];
        flag_nxt[FLAG_V] = res_v;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
            flags <= '0;
        end else if (alu_en) begin
            // ALU owns the cycle; a concurrent user write is dropped
            if (res_wr) regs[write_addr] <= res;
            if (flag_en) flags <= flag_nxt;
        end else if (write_en) begin
            regs[write_addr] <= user_write_data;
        end
    end

    assign alu_zero  = flags[FLAG_Z];
    assign alu_carry = flags[FLAG_C];
    assign alu_neg   = flags[FLAG_N];
    assign alu_ovf   = flags[FLAG_V];

endmodule

// File: tb/tb_datapath_pn.sv
// tb_datapath_pn: directed plan plus random traffic for datapath_pn,
// checked against an arithmetic reference model.
module tb_datapath_pn;

    localparam int W    = 8;
    localparam int NR   = 16;
    localparam int M    = 1 << W;
    localparam int HALF = 1 << (W - 1);

    logic         clk = 1'b0;
    logic         rst_n;
    logic         write_en;
    logic [3:0]   write_addr;
    logic [W-1:0] user_write_data;
    logic [3:0]   ra_addr;
    logic [3:0]   rb_addr;
    logic         alu_en;
    logic [3:0]   alu_opcode;
    logic [W-1:0] read_a;
    logic [W-1:0] read_b;
    logic         alu_zero;
    logic         alu_carry;
    logic         alu_neg;
    logic         alu_ovf;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    int m_reg [NR];
    bit mz, mc, mn, mv;

    datapath_pn dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .write_en        (write_en),
        .write_addr      (write_addr),
        .user_write_data (user_write_data),
        .ra_addr         (ra_addr),
        .rb_addr         (rb_addr),
        .alu_en          (alu_en),
        .alu_opcode      (alu_opcode),
        .read_a          (read_a),
        .read_b          (read_b),
        .alu_zero        (alu_zero),
        .alu_carry       (alu_carry),
        .alu_neg         (alu_neg),
        .alu_ovf         (alu_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int sgn(input int x);
        return (x >= HALF) ? x - M : x;
    endfunction

    // reference: one clock edge of the datapath, from current inputs
    task automatic model_edge();
        int a, b, t, st, res;
        bit c, v, wr, fl;
        if (!rst_n) begin
            for (int i = 0; i < NR; i++) m_reg[i] = 0;
            {mz, mc, mn, mv} = 4'b0;
            return;
        end
        if (!alu_en) begin
            if (write_en) m_reg[write_addr] = user_write_data;
            return;
        end
        a = m_reg[ra_addr];
        b = m_reg[rb_addr];
        res = 0; c = 0; v = 0;
        wr = (alu_opcode <= 10);
        fl = (alu_opcode <= 11);
        case (int'(alu_opcode))
            0, 8: begin
                t  = a + b + ((alu_opcode == 8) ? int'(mc) : 0);
                st = sgn(a) + sgn(b) + ((alu_opcode == 8) ? int'(mc) : 0);
                res = t % M;
                c = (t >= M);
                v = (st >= HALF) || (st < -HALF);
            end
            1, 9, 11: begin
                t  = a - b - ((alu_opcode == 9) ? int'(mc) : 0);
                st = sgn(a) - sgn(b) - ((alu_opcode == 9) ? int'(mc) : 0);
                res = (t + 2 * M) % M;
                c = (t < 0);
                v = (st >= HALF) || (st < -HALF);
            end
            2: res = a & b;
            3: res = a | b;
            4: res = a ^ b;
            5: res = (M - 1) - a;
            6: begin res = (a * 2) % M; c = (a >= HALF); end
            7: begin res = a / 2; c = (a % 2 == 1); end
            10: res = b;
            default: ;
        endcase
        if (wr) m_reg[write_addr] = res;
        if (fl) begin
            mz = (res == 0);
            mc = c;
            mn = (res >= HALF);
            mv = v;
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        write_en = 1'b0;
        alu_en   = 1'b0;
    endtask

    task automatic wr(input int a, input int d);
        alu_en = 1'b0;
        write_en = 1'b1;
        write_addr = 4'(a);
        user_write_data = W'(d);
        tick();
        write_en = 1'b0;
    endtask

    task automatic op(input int o, input int a, input int b, input int w);
        write_en = 1'b0;
        alu_en = 1'b1;
        alu_opcode = 4'(o);
        ra_addr = 4'(a);
        rb_addr = 4'(b);
        write_addr = 4'(w);
        tick();
        alu_en = 1'b0;
    endtask

    task automatic exp_reg(input string tag, input int r, input int exp);
        idle();
        ra_addr = 4'(r);
        rb_addr = 4'(r);
        #1;
        chk(tag, 32'(read_a), 32'(exp));
        chk({tag, "_b"}, 32'(read_b), 32'(m_reg[r]));
    endtask

    task automatic exp_flags(input string tag, input logic [3:0] vncz);
        chk(tag, 32'({alu_ovf, alu_neg, alu_carry, alu_zero}), 32'(vncz));
    endtask

    task automatic sweep(input string tag);
        idle();
        for (int i = 0; i < NR; i++) begin
            ra_addr = 4'(i);
            rb_addr = 4'(NR - 1 - i);
            #1;
            chk({tag, "_a"}, 32'(read_a), 32'(m_reg[i]));
            chk({tag, "_b"}, 32'(read_b), 32'(m_reg[NR - 1 - i]));
        end
    endtask

    initial begin
        for (int i = 0; i < NR; i++) m_reg[i] = 0;
        rst_n = 1'b0;
        idle();
        write_addr = '0;
        user_write_data = '0;
        ra_addr = '0;
        rb_addr = '0;
        alu_opcode = '0;
        #2;
        tick();
        tick();
        rst_n = 1'b1;

        // reset and fill
        for (int i = 0; i < NR; i++) begin
            ra_addr = 4'(i);
            rb_addr = 4'(i);
            #1;
            chk("rst_a", 32'(read_a), 32'h0);
            chk("rst_b", 32'(read_b), 32'h0);
        end
        exp_flags("rst_flags", 4'b0000);
        for (int i = 0; i < NR; i++) wr(i, i * 8'h11);
        for (int i = 0; i < NR; i++) begin
            ra_addr = 4'(i);
            rb_addr = 4'(NR - 1 - i);
            #1;
            chk("fill_a", 32'(read_a), 32'(i * 8'h11));
            chk("fill_b", 32'(read_b), 32'((NR - 1 - i) * 8'h11));
        end

        // increment loop
        wr(0, 1);
        wr(1, 0);
        alu_en = 1'b1;
        alu_opcode = 4'd0;
        ra_addr = 4'd1;
        rb_addr = 4'd0;
        write_addr = 4'd1;
        for (int i = 0; i < 64; i++) tick();
        exp_reg("inc_r1", 1, 8'h40);
        exp_flags("inc_flags", 4'b0000);

        // carry chain
        wr(2, 8'hFF);
        wr(3, 8'h01);
        wr(4, 8'h00);
        op(0, 2, 3, 2);
        exp_reg("add_r2", 2, 8'h00);
        exp_flags("add_flags", 4'b0011);
        op(8, 4, 4, 5);
        exp_reg("adc_r5", 5, 8'h01);
        exp_flags("adc_flags", 4'b0000);

        // compare and signed overflow
        wr(6, 8'h10);
        wr(7, 8'h20);
        op(11, 6, 7, 6);
        exp_flags("cmp_flags", 4'b0110);
        exp_reg("cmp_r6", 6, 8'h10);
        wr(9, 8'h80);
        wr(10, 8'h01);
        op(1, 9, 10, 11);
        exp_reg("sub_r11", 11, 8'h7F);
        exp_flags("sub_flags", 4'b1000);

        // conflict: ALU wins, reserved op writes nothing
        wr(12, 8'h5A);
        alu_en = 1'b1;
        write_en = 1'b1;
        alu_opcode = 4'd10;
        rb_addr = 4'd12;
        ra_addr = 4'd0;
        write_addr = 4'd8;
        user_write_data = 8'hAA;
        tick();
        exp_reg("mov_r8", 8, 8'h5A);
        exp_flags("mov_flags", 4'b0000);
        op(11, 6, 7, 0);
        alu_en = 1'b1;
        write_en = 1'b1;
        alu_opcode = 4'd13;
        write_addr = 4'd8;
        user_write_data = 8'hAA;
        tick();
        exp_reg("rsv_r8", 8, 8'h5A);
        exp_flags("rsv_flags", 4'b0110);

        // reset in the middle of a running loop
        wr(0, 1);
        wr(1, 0);
        alu_en = 1'b1;
        alu_opcode = 4'd0;
        ra_addr = 4'd1;
        rb_addr = 4'd0;
        write_addr = 4'd1;
        for (int i = 0; i < 5; i++) tick();
        rst_n = 1'b0;
        write_en = 1'b1;
        tick();
        rst_n = 1'b1;
        idle();
        for (int i = 0; i < NR; i++) begin
            ra_addr = 4'(i);
            rb_addr = 4'(i);
            #1;
            chk("mid_rst_a", 32'(read_a), 32'h0);
            chk("mid_rst_b", 32'(read_b), 32'h0);
        end
        exp_flags("mid_rst_flags", 4'b0000);

        // random traffic against the model
        for (int n = 0; n < 2000; n++) begin
            rst_n = ($urandom_range(99) != 0);
            write_en = 1'($urandom);
            alu_en = ($urandom_range(2) != 0);
            alu_opcode = 4'($urandom);
            ra_addr = 4'($urandom);
            rb_addr = 4'($urandom);
            write_addr = ($urandom_range(3) == 0) ? ra_addr : 4'($urandom);
            user_write_data = W'($urandom);
            tick();
            chk("rnd_a", 32'(read_a), 32'(m_reg[ra_addr]));
            chk("rnd_b", 32'(read_b), 32'(m_reg[rb_addr]));
            chk("rnd_flags", 32'({alu_ovf, alu_neg, alu_carry, alu_zero}),
                32'({mv, mn, mc, mz}));
        end
        rst_n = 1'b1;
        sweep("final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/datapath_pn.md
# datapath_pn

Parametrised successor to the 16×8 register-file/ALU datapath. It generalises register count and data width, widens the opcode to 4 bits and adds carry-chained ops (ADC/SBC), a flags-only compare, a MOV and registered zero/carry/negative/overflow flags. It is the execute core that the ProtoCore control unit drives each cycle.

## Interface
Parameters:
- DATA_W, 8, width of registers, ALU operands and result
- REG_COUNT, 16, number of registers; power of two, at least 2
- ADDR_W, $clog2(REG_COUNT), register address width (derived; do not override)

Ports:
- clk  in  1  single clock; all state updates on its rising edge
- rst_n  in  1  synchronous, active-low reset
- write_en  in  1  user write strobe
- write_addr  in  ADDR_W  destination register for both user write and ALU writeback
- user_write_data  in  DATA_W  user write data
- ra_addr  in  ADDR_W  read port A address; ALU operand A
- rb_addr  in  ADDR_W  read port B address; ALU operand B
- alu_en  in  1  execute alu_opcode this cycle
- alu_opcode  in  4  operation select
- read_a  out  DATA_W  contents of reg[ra_addr]
- read_b  out  DATA_W  contents of reg[rb_addr]
- alu_zero, alu_carry, alu_neg, alu_ovf  out  1 each  registered flags

## Operation
- Opcodes: 0 ADD A+B; 1 SUB A−B; 2 AND; 3 OR; 4 XOR; 5 NOT ~A; 6 SHL A<<1; 7 SHR A>>1 (logical); 8 ADC A+B+C; 9 SBC A−B−C; 10 MOV B; 11 CMP (A−B, flags only); 12–15 reserved.
- C is the current alu_carry flag value.
- All arithmetic is at DATA_W bits and the result wraps modulo 2^DATA_W.
- Carry:
  - ADD/ADC: carry-out.
  - SUB/SBC/CMP: borrow (1 when the unsigned true result is below 0).
  - SHL: A[DATA_W−1]. SHR: A[0].
  - Logic ops and MOV: 0.
- Overflow: signed overflow for ADD/ADC/SUB/SBC/CMP; 0 otherwise.
- Negative: result MSB. Zero: result == 0.
- Writeback when alu_en=1:
  - Opcodes 0–10: result is written to reg[write_addr] and all four flags are updated.
  - CMP: only the flags are updated.
  - Reserved opcodes: no write, flags held.
- write_en=1 and alu_en=0: reg[write_addr] ← user_write_data. Flags held.
- alu_en=1 and write_en=1 in the same cycle: ALU path wins and the user write is discarded. With CMP or a reserved opcode, neither write occurs.
- Neither strobe asserted: no state change.

## Timing
- Reads are combinational from register storage. A write becomes visible on read_a/read_b in the cycle after its edge. A read in the same cycle returns the old value, with no bypass.
- ALU latency is one edge: operands are read, the result is computed combinationally, and register and flags update at the same rising edge.
- Back-to-back dependent ops (the destination is the next op's source) are legal every cycle.
- Flags are outputs of a flag register, so they reflect the last executed op, not the current one.
- Reset: when rst_n=0 at a rising edge, all REG_COUNT registers and all flags go to 0, so read_a and read_b read 0.
  - Reset overrides any concurrent alu_en or write_en.
  - Reset asserted mid-sequence discards the in-flight op.
- Before the first reset, contents are undefined, and the bench does not check them.
- Source and destination may be the same register. ALU inputs use pre-edge values, so no hazard exists.

## Structure
- datapath_pkg holds:
  - opcode localparams OP_ADD…OP_CMP (4 bits);
  - flag bit-index constants;
  - a function giving the default DATA_W/REG_COUNT.
- One sub-module, datapath_alu: purely combinational, parametrised by DATA_W. Its inputs are a, b, cin and op; its outputs are result, carry, ovf and a write-valid indication.
- The register array, writeback priority and flag register live in the top, datapath_pn.

## Test plan
Defaults apply (DATA_W=8, REG_COUNT=16).
- Reset and fill: pulse rst_n low, then read every register → 0x00 on both ports. Write i·0x11 to reg i, then sweep ra=i, rb=15−i → read_a=i·0x11, read_b=(15−i)·0x11.
- Increment loop: reg0=0x01, reg1=0x00. With ra=1, rb=0, wa=1, ADD, hold alu_en for 64 cycles → reg1=0x40, zero=0, carry=0.
- Carry chain:
  - Setup: reg2=0xFF, reg3=0x01, reg4=0x00.
  - ADD ra=2, rb=3, wa=2 → reg2=0x00, zero=1, carry=1.
  - Then ADC ra=4, rb=4, wa=5 → reg5=0x01, carry=0.
- Compare: reg6=0x10, reg7=0x20. CMP ra=6, rb=7, wa=6 → carry=1, neg=1, zero=0, reg6 still 0x10. Then SUB 0x80−0x01 → 0x7F, ovf=1.
- Conflict: in one cycle, alu_en=1 with MOV (rb=reg holding 0x5A), write_en=1, user data 0xAA, wa=8 → reg8=0x5A. Reserved opcode 13 with write_en=1 → reg8 unchanged and flags unchanged.
- Reset mid-operation: during the increment loop, drop rst_n for one edge → every register reads 0x00 and all flags are 0. The ALU op in that cycle has no effect.
